// File: rtl/writeback_regfile.sv
// Write-back receiving register file: 32 x XLEN integer registers, two combinational
// read ports and a per-register pending scoreboard gating issue. Optional macro WB_BYPASS_EN.
module writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_wb_rd_wvalid,
    input  logic [4:0]      i_wb_rd_waddr,
    input  logic [XLEN-1:0] i_wb_rd_wdata,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_rdata,
    output logic [XLEN-1:0] o_rs2_rdata,
    input  logic            i_issue_valid,
    input  logic            i_issue_rs1_used,
    input  logic            i_issue_rs2_used,
    input  logic [4:0]      i_issue_rd,
    output logic            o_issue_ready,
    output logic            o_busy,
    output logic            o_wb_err
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    logic             r_wb_err;

    logic             w_wb_wr;
    logic             w_wb_hit1;
    logic             w_wb_hit2;
    logic             w_clear1;
    logic             w_clear2;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_issue_set;
    logic [XLEN-1:0]  w_rs1_arr;
    logic [XLEN-1:0]  w_rs2_arr;
    logic [NREGS-1:0] w_pending_nxt;

    assign w_wb_wr   = i_wb_rd_wvalid && (i_wb_rd_waddr != '0);
    assign w_wb_hit1 = i_wb_rd_wvalid && (i_wb_rd_waddr == i_rs1_addr);
    assign w_wb_hit2 = i_wb_rd_wvalid && (i_wb_rd_waddr == i_rs2_addr);

    assign w_rs1_arr = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
    assign w_rs2_arr = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];

`ifdef WB_BYPASS_EN
    // A register being written back this cycle is read from the wb bus, so RAW need not stall.
    assign w_clear1    = w_wb_hit1;
    assign w_clear2    = w_wb_hit2;
    assign o_rs1_rdata = (w_wb_hit1 && (i_rs1_addr != '0)) ? i_wb_rd_wdata : w_rs1_arr;
    assign o_rs2_rdata = (w_wb_hit2 && (i_rs2_addr != '0)) ? i_wb_rd_wdata : w_rs2_arr;
`else
    assign w_clear1    = 1'b0;
    assign w_clear2    = 1'b0;
    assign o_rs1_rdata = w_rs1_arr;
    assign o_rs2_rdata = w_rs2_arr;
`endif

    assign w_raw1 = i_issue_rs1_used && (i_rs1_addr != '0) && r_pending[i_rs1_addr] && !w_clear1;
    assign w_raw2 = i_issue_rs2_used && (i_rs2_addr != '0) && r_pending[i_rs2_addr] && !w_clear2;
    assign w_waw  = (i_issue_rd != '0) && r_pending[i_issue_rd]
                    && !(i_wb_rd_wvalid && (i_wb_rd_waddr == i_issue_rd));

    assign o_issue_ready = !(w_raw1 || w_raw2 || w_waw);
    assign w_issue_set   = i_issue_valid && o_issue_ready && (i_issue_rd != '0);
    assign o_busy        = |r_pending;
    assign o_wb_err      = r_wb_err;

    // Set is applied after clear so a same-cycle issue to the written register stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wb_wr) begin
            w_pending_nxt[i_wb_rd_waddr] = 1'b0;
        end
        if (w_issue_set) begin
            w_pending_nxt[i_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
            r_wb_err  <= 1'b0;
        end else begin
            if (w_wb_wr) begin
                r_regs[i_wb_rd_waddr] <= i_wb_rd_wdata;
                if (!r_pending[i_wb_rd_waddr]) begin
                    r_wb_err <= 1'b1;
                end
            end
            r_pending <= w_pending_nxt;
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a high-level register/scoreboard model checked
// every cycle, plus hand-computed literal expectations along the directed sequence.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic        issue_valid = 1'b0;
    logic        rs1_used = 1'b0;
    logic        rs2_used = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        busy;
    logic        wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_wb_rd_wvalid   (wb_valid),
        .i_wb_rd_waddr    (wb_addr),
        .i_wb_rd_wdata    (wb_data),
        .i_rs1_addr       (rs1_addr),
        .i_rs2_addr       (rs2_addr),
        .o_rs1_rdata      (rs1_rdata),
        .o_rs2_rdata      (rs2_rdata),
        .i_issue_valid    (issue_valid),
        .i_issue_rs1_used (rs1_used),
        .i_issue_rs2_used (rs2_used),
        .i_issue_rd       (issue_rd),
        .o_issue_ready    (issue_ready),
        .o_busy           (busy),
        .o_wb_err         (wb_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_err;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    initial model_reset();

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (wb_valid && wb_addr == a) return wb_data;
`endif
        return m_regs[a];
    endfunction

    function automatic bit m_src_blocks(input bit used, input logic [4:0] a);
        bit fwd;
`ifdef WB_BYPASS_EN
        fwd = wb_valid && (wb_addr == a);
`else
        fwd = 1'b0;
`endif
        return used && (a != 0) && m_pend[a] && !fwd;
    endfunction

    function automatic bit m_ready();
        bit waw;
        waw = (issue_rd != 0) && m_pend[issue_rd] && !(wb_valid && wb_addr == issue_rd);
        return !(m_src_blocks(rs1_used, rs1_addr) || m_src_blocks(rs2_used, rs2_addr) || waw);
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < 32; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_reset();
        end else begin
            bit rdy;
            rdy = m_ready();
            if (wb_valid && wb_addr != 0) begin
                if (!m_pend[wb_addr]) m_err = 1'b1;
                m_regs[wb_addr] = wb_data;
                m_pend[wb_addr] = 1'b0;
            end
            if (issue_valid && rdy && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rs1", rs1_rdata, m_read(rs1_addr));
        chk("model_rs2", rs2_rdata, m_read(rs2_addr));
        chk("model_ready", 32'(issue_ready), 32'(m_ready()));
        chk("model_busy", 32'(busy), 32'(m_busy()));
        chk("model_err", 32'(wb_err), 32'(m_err));
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                         input bit iv, input bit u1, input logic [4:0] a1,
                         input bit u2, input logic [4:0] a2, input logic [4:0] rd);
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        issue_valid = iv; rs1_used = u1; rs1_addr = a1;
        rs2_used = u2; rs2_addr = a2; issue_rd = rd;
    endtask

    task automatic to_neg();
        @(negedge clk); #1;
    endtask

    task automatic to_pos();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        to_pos();

        // issue rd=5, then RAW on rs1=5
        drive(0, 0, 0, 1, 0, 0, 0, 0, 5);
        to_neg(); chk("A_ready", 32'(issue_ready), 1); chk("A_busy", 32'(busy), 0);
        to_pos();
        drive(0, 0, 0, 1, 1, 5, 0, 0, 0);
        to_neg(); chk("B_ready", 32'(issue_ready), 0); chk("B_busy", 32'(busy), 1);
        to_pos();
        drive(1, 5, 32'hDEADBEEF, 1, 1, 5, 0, 0, 0);
        to_neg();
`ifdef WB_BYPASS_EN
        chk("C_ready", 32'(issue_ready), 1); chk("C_rs1", rs1_rdata, 32'hDEADBEEF);
`else
        chk("C_ready", 32'(issue_ready), 0); chk("C_rs1", rs1_rdata, 32'h0);
`endif
        to_pos();
        drive(0, 0, 0, 1, 1, 5, 0, 0, 0);
        to_neg(); chk("D_ready", 32'(issue_ready), 1); chk("D_rs1", rs1_rdata, 32'hDEADBEEF);
        chk("D_busy", 32'(busy), 0);
        to_pos();

        // write to x0 is ignored
        drive(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
        to_pos();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg(); chk("E_x0", rs1_rdata, 0); chk("E_err", 32'(wb_err), 0);
        to_pos();

        // write-back to a non-pending register
        drive(1, 7, 32'hCAFEF00D, 0, 0, 0, 0, 7, 0);
        to_neg(); chk("F_err_pre", 32'(wb_err), 0);
        to_pos();
        drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
        to_neg(); chk("F_rs2", rs2_rdata, 32'hCAFEF00D); chk("F_err", 32'(wb_err), 1);
        to_pos();

        // same-cycle set and clear of x3
        drive(0, 0, 0, 1, 0, 0, 0, 0, 3);
        to_pos();
        drive(1, 3, 32'h33, 1, 0, 0, 0, 0, 3);
        to_neg(); chk("G_ready", 32'(issue_ready), 1);
        to_pos();
        drive(0, 0, 0, 1, 0, 3, 0, 0, 3);
        to_neg(); chk("G_waw", 32'(issue_ready), 0); chk("G_busy", 32'(busy), 1);
        chk("G_rs1", rs1_rdata, 32'h33);
        to_pos();
        drive(1, 3, 32'h44, 0, 0, 0, 0, 0, 0);
        to_pos();
        drive(0, 0, 0, 0, 0, 3, 0, 0, 0);
        to_neg(); chk("H_busy", 32'(busy), 0); chk("H_err", 32'(wb_err), 1);
        chk("H_rs1", rs1_rdata, 32'h44);
        to_pos();

        // x9: accept, RAW on rs2, WAW until write-back
        drive(0, 0, 0, 1, 1, 9, 0, 0, 9);
        to_neg(); chk("I_ready", 32'(issue_ready), 1);
        to_pos();
        drive(0, 0, 0, 1, 0, 0, 1, 9, 0);
        to_neg(); chk("I_raw2", 32'(issue_ready), 0);
        to_pos();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 9);
        to_neg(); chk("I_waw", 32'(issue_ready), 0);
        to_pos();
        drive(1, 9, 32'h99, 1, 0, 0, 0, 0, 9);
        to_neg(); chk("I_waw_clr", 32'(issue_ready), 1);
        to_pos();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 9);
        to_neg(); chk("I_waw2", 32'(issue_ready), 0); chk("I_busy", 32'(busy), 1);
        to_pos();
        drive(1, 9, 32'h9A, 0, 0, 0, 0, 0, 0);
        to_pos();
        drive(0, 0, 0, 0, 0, 9, 0, 0, 0);
        to_neg(); chk("I_idle", 32'(busy), 0); chk("I_rs1", rs1_rdata, 32'h9A);
        to_pos();

        // asynchronous reset mid-cycle
        drive(0, 0, 0, 1, 0, 0, 0, 0, 12);
        to_pos();
        drive(0, 0, 0, 1, 0, 7, 0, 5, 12);
        to_neg(); chk("J_ready_pre", 32'(issue_ready), 0); chk("J_rs1_pre", rs1_rdata, 32'hCAFEF00D);
        chk("J_rs2_pre", rs2_rdata, 32'hDEADBEEF);
        #2 rstn = 1'b0;
        #1;
        chk("J_rs1", rs1_rdata, 0); chk("J_rs2", rs2_rdata, 0);
        chk("J_busy", 32'(busy), 0); chk("J_ready", 32'(issue_ready), 1);
        chk("J_err", 32'(wb_err), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2 rstn = 1'b1;

        // stale write-back after reset flags an error
        drive(1, 5, 32'h55, 0, 0, 0, 0, 0, 0);
        to_neg(); chk("K_err_pre", 32'(wb_err), 0);
        to_pos();
        drive(0, 0, 0, 0, 0, 5, 0, 0, 0);
        to_neg(); chk("K_err", 32'(wb_err), 1); chk("K_rs1", rs1_rdata, 32'h55);
        to_pos();
        repeat (2) to_pos();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
